// File: rtl/phase_monitor.sv
// rtl/phase_monitor.sv - lock-on checker for the 8-cycle phase counter stream
//
// Purpose: follows the upstream 2-bit phase code (run of phase 1, run of
// phase 2, run of phase 0, repeating). It checks the order and run length
// of every phase, strobes frame_done and counts each fully validated frame,
// and keeps the first protocol violation in sticky error status.
//
// Ports:
//   clk        - clock, rising edge
//   rstb       - asynchronous active-low reset
//   phase_in   - phase code from upstream (0,1,2 legal; 3 illegal)
//   clr        - synchronous clear of frame_cnt/err/err_code (FSM untouched)
//   locked     - FSM is in P1, P2 or P0
//   frame_done - one-cycle pulse per validated frame
//   frame_cnt  - saturating count of validated frames
//   err        - sticky error flag
//   err_code   - first error: 1 illegal, 2 run too short, 3 run too long

module phase_monitor #(
   parameter int LEN1    = 4,
   parameter int LEN2    = 3,
   parameter int LEN0    = 1,
   parameter int RUN_W   = 4,
   parameter int FRAME_W = 8
) (
   input  logic               clk,
   input  logic               rstb,
   input  logic [1:0]         phase_in,
   input  logic               clr,
   output logic               locked,
   output logic               frame_done,
   output logic [FRAME_W-1:0] frame_cnt,
   output logic               err,
   output logic [1:0]         err_code
);

   typedef enum logic [1:0] {HUNT, P1, P2, P0} state_t;

   localparam logic [1:0] ERR_ILLEGAL = 2'd1;
   localparam logic [1:0] ERR_SHORT   = 2'd2;
   localparam logic [1:0] ERR_LONG    = 2'd3;

   // One bit wider than run so the long check sees run+1 without wrapping.
   localparam logic [RUN_W:0] L1 = (RUN_W+1)'(LEN1);
   localparam logic [RUN_W:0] L2 = (RUN_W+1)'(LEN2);
   localparam logic [RUN_W:0] L0 = (RUN_W+1)'(LEN0);

   state_t           state, state_n;
   logic [1:0]       prev;
   logic [RUN_W-1:0] run, run_n;
   logic [RUN_W:0]   run_ext, run_inc;
   logic [RUN_W-1:0] run_sat;
   logic             ev_frame, ev_err;
   logic [1:0]       ev_code;
   logic [RUN_W:0]   cur_len;
   logic [1:0]       cur_code, next_code;
   state_t           next_state;

   assign run_ext = {1'b0, run};
   assign run_inc = run_ext + (RUN_W+1)'(1);
   assign run_sat = (&run) ? run : run + RUN_W'(1);

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         state <= HUNT;
         prev  <= 2'b11;
         run   <= '0;
      end else begin
         state <= state_n;
         prev  <= phase_in;
         run   <= run_n;
      end
   end

   // Per-state view: which code continues the run, which code is the legal
   // exit, and what length the run must have reached before that exit.
   always_comb begin
      cur_len    = L1;
      cur_code   = 2'd1;
      next_code  = 2'd2;
      next_state = P2;
      case (state)
         P2: begin
            cur_len    = L2;
            cur_code   = 2'd2;
            next_code  = 2'd0;
            next_state = P0;
         end
         P0: begin
            cur_len    = L0;
            cur_code   = 2'd0;
            next_code  = 2'd1;
            next_state = P1;
         end
         default: ;
      endcase
   end

   always_comb begin
      state_n  = state;
      run_n    = run;
      ev_frame = 1'b0;
      ev_err   = 1'b0;
      ev_code  = 2'd0;
      case (state)
         HUNT: begin
            run_n = '0;
            if (prev == 2'd0 && phase_in == 2'd1) begin
               state_n = P1;
               run_n   = RUN_W'(1);
            end
         end
         P1, P2, P0: begin
            if (phase_in == cur_code) begin
               if (run_inc > cur_len) begin
                  ev_err  = 1'b1;
                  ev_code = ERR_LONG;
               end else begin
                  run_n = run_sat;
               end
            end else if (phase_in == next_code) begin
               if (run_ext == cur_len) begin
                  state_n  = next_state;
                  run_n    = RUN_W'(1);
                  // Only the P0 -> P1 exit closes a frame.
                  ev_frame = (state == P0);
               end else begin
                  ev_err  = 1'b1;
                  ev_code = ERR_SHORT;
               end
            end else begin
               ev_err  = 1'b1;
               ev_code = ERR_ILLEGAL;
            end
         end
         default: state_n = HUNT;
      endcase
      if (ev_err) begin
         state_n = HUNT;
         run_n   = '0;
      end
   end

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         locked     <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         locked     <= (state_n != HUNT);
         frame_done <= ev_frame;
      end
   end

   // clr takes effect first; a frame at the same edge then counts on top.
   logic [FRAME_W-1:0] frame_base;
   assign frame_base = clr ? '0 : frame_cnt;

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         frame_cnt <= '0;
      end else if (ev_frame && !(&frame_base)) begin
         frame_cnt <= frame_base + FRAME_W'(1);
      end else begin
         frame_cnt <= frame_base;
      end
   end

   // err_code is only written when no error is pending after clr, so the
   // first violation since the last clear is kept.
   logic       err_base;
   logic [1:0] code_base;
   assign err_base  = clr ? 1'b0 : err;
   assign code_base = clr ? 2'd0 : err_code;

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         err      <= 1'b0;
         err_code <= 2'd0;
      end else begin
         err      <= err_base | ev_err;
         err_code <= (ev_err && !err_base) ? ev_code : code_base;
      end
   end

endmodule
